// File: rtl/mc_bus.sv
// Single-master bus splitter: decodes a request to one of NSLV slaves, waits for
// that slave's completion (or a cycle timeout) and returns a one-cycle response.
module mc_bus #(
  parameter int                 NSLV     = 3,
  parameter logic [NSLV*32-1:0] SLV_BASE = {32'hFF000004, 32'hFF000000, 32'h00000000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFF000000},
  parameter int                 TIMEOUT  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  output logic                 ready_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic [NSLV-1:0]      slv_req_o,
  output logic                 slv_we_o,
  output logic [31:0]          slv_addr_o,
  output logic [31:0]          slv_wdata_o,
  output logic [3:0]           slv_be_o,
  input  logic [NSLV-1:0]      slv_ready_i,
  input  logic [NSLV*32-1:0]   slv_rdata_i
);

  // state  | meaning
  // IDLE   | waiting for req_i; next accepted request is latched here
  // ACCESS | selected slave is strobed until it is ready or the timer expires
  // DONE   | one-cycle response on ready_o, requests ignored
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [1:0]    state;
  logic [IW-1:0] idx_q;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          sel_ready;
  logic [31:0]   sel_rdata;

  // Scanning from the top index down lets the lowest matching window win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if ((addr_i & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32]) begin
        hit     = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == IW'(k)) begin
        sel_ready = slv_ready_i[k];
        sel_rdata = slv_rdata_i[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      slv_addr_o  <= '0;
      slv_wdata_o <= '0;
      slv_be_o    <= '0;
      cnt         <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            idx_q       <= hit_idx;
            we_q        <= we_i;
            slv_addr_o  <= addr_i;
            slv_wdata_o <= wdata_i;
            slv_be_o    <= be_i;
            cnt         <= CNT_LOAD;
            if (hit) begin
              state <= ST_ACCESS;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_ACCESS: begin
          // Slave completion outranks a timeout landing on the same cycle.
          if (sel_ready) begin
            rdata_q <= we_q ? 32'd0 : sel_rdata;
            err_q   <= 1'b0;
            state   <= ST_DONE;
          end else if ((TIMEOUT > 0) && (cnt == '0)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= ST_DONE;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    slv_req_o = '0;
    if (state == ST_ACCESS) slv_req_o[idx_q] = 1'b1;
  end

  assign slv_we_o = (state == ST_ACCESS) && we_q;
  assign ready_o  = (state == ST_DONE);
  assign busy_o   = (state != ST_IDLE);
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule
